// File: rtl/strokie_pkg.sv
// Shared types, constants and FP16/FP32 packing helpers for the strokie ALU
// issue stage.
package strokie_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic        MODE_FP16 = 1'b0;
  localparam logic        MODE_FP32 = 1'b1;
  localparam logic [1:0]  OP_ADD    = 2'b00;
  localparam logic [31:0] QNAN32    = 32'h7FC0_0000;
  localparam logic [15:0] QNAN16    = 16'h7E00;

  // The ALU expects FP16 operands in its upper half.
  function automatic logic [31:0] pack_operand(input logic [31:0] data,
                                               input logic        mode_fp);
    return (mode_fp == MODE_FP32) ? data : {data[15:0], 16'h0000};
  endfunction

  function automatic logic [31:0] unpack_result(input logic [31:0] q,
                                                input logic        mode_fp);
    return (mode_fp == MODE_FP32) ? q : {16'h0000, q[31:16]};
  endfunction

  function automatic logic [31:0] qnan_result(input logic mode_fp);
    return (mode_fp == MODE_FP32) ? QNAN32 : {16'h0000, QNAN16};
  endfunction

endpackage

// File: rtl/strokie_req_fifo.sv
// Synchronous request FIFO with combinational head read, full/empty flags and
// an occupancy count. Push and pop in the same cycle are both honoured.
module strokie_req_fifo
  import strokie_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 39
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wr_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          do_push, do_pop;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (do_pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/strokie_alu_issue.sv
// Issue/collect stage for strokie_alu: queues FP add requests, drives the ALU
// one request at a time and returns tagged results, with a timeout fallback.
module strokie_alu_issue
  import strokie_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [1:0]       req_op,
  input  logic             req_mode_fp,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      alu_A,
  output logic [31:0]      alu_B,
  output logic [1:0]       alu_op,
  output logic             alu_mode_fp,
  input  logic [31:0]      alu_Q,
  input  logic             alu_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_q,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_timeout,
  output logic             busy
);

  // Each entry carries both operands, op, mode and tag.
  localparam int ENTRY_W = 64 + 2 + 1 + TAG_W;
  localparam int CW      = $clog2(TIMEOUT);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

  state_t           state_reg, state_next;
  logic [CW-1:0]    wcnt_reg, wcnt_next;
  logic [31:0]      alu_a_reg, alu_a_next;
  logic [31:0]      alu_b_reg, alu_b_next;
  logic [1:0]       alu_op_reg, alu_op_next;
  logic             alu_mode_reg, alu_mode_next;
  logic [TAG_W-1:0] tag_reg, tag_next;
  logic             res_valid_reg, res_valid_next;
  logic [31:0]      res_q_reg, res_q_next;
  logic [TAG_W-1:0] res_tag_reg, res_tag_next;
  logic             res_timeout_reg, res_timeout_next;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_wr_data, fifo_rd_data;
  logic [TAG_W-1:0]   head_tag;
  logic               head_mode;
  logic [1:0]         head_op;
  logic [31:0]        head_a, head_b;

  assign fifo_wr_data = {req_tag, req_mode_fp, req_op, req_a, req_b};
  assign {head_tag, head_mode, head_op, head_a, head_b} = fifo_rd_data;
  assign req_ready    = !fifo_full;
  assign fifo_push    = req_valid && !fifo_full;
  // The head leaves the FIFO exactly on the edge that enters ISSUE.
  assign fifo_pop     = !fifo_empty &&
                        ((state_reg == IDLE) || ((state_reg == DONE) && res_ready));

  strokie_req_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_req_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_next       = state_reg;
    wcnt_next        = wcnt_reg;
    alu_a_next       = alu_a_reg;
    alu_b_next       = alu_b_reg;
    alu_op_next      = alu_op_reg;
    alu_mode_next    = alu_mode_reg;
    tag_next         = tag_reg;
    res_valid_next   = res_valid_reg;
    res_q_next       = res_q_reg;
    res_tag_next     = res_tag_reg;
    res_timeout_next = res_timeout_reg;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) state_next = ISSUE;
      end
      ISSUE: begin
        wcnt_next  = '0;
        state_next = WAIT;
      end
      WAIT: begin
        // A real answer wins over a timeout landing on the same cycle.
        if (alu_ready) begin
          res_q_next       = unpack_result(alu_Q, alu_mode_reg);
          res_timeout_next = 1'b0;
          res_tag_next     = tag_reg;
          res_valid_next   = 1'b1;
          state_next       = DONE;
        end else if (wcnt_reg == WCNT_LAST) begin
          res_q_next       = qnan_result(alu_mode_reg);
          res_timeout_next = 1'b1;
          res_tag_next     = tag_reg;
          res_valid_next   = 1'b1;
          state_next       = DONE;
        end else begin
          wcnt_next = wcnt_reg + 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          state_next     = fifo_empty ? IDLE : ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (fifo_pop) begin
      alu_a_next    = pack_operand(head_a, head_mode);
      alu_b_next    = pack_operand(head_b, head_mode);
      alu_op_next   = head_op;
      alu_mode_next = head_mode;
      tag_next      = head_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      wcnt_reg        <= '0;
      alu_a_reg       <= '0;
      alu_b_reg       <= '0;
      alu_op_reg      <= '0;
      alu_mode_reg    <= 1'b0;
      tag_reg         <= '0;
      res_valid_reg   <= 1'b0;
      res_q_reg       <= '0;
      res_tag_reg     <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wcnt_reg        <= wcnt_next;
      alu_a_reg       <= alu_a_next;
      alu_b_reg       <= alu_b_next;
      alu_op_reg      <= alu_op_next;
      alu_mode_reg    <= alu_mode_next;
      tag_reg         <= tag_next;
      res_valid_reg   <= res_valid_next;
      res_q_reg       <= res_q_next;
      res_tag_reg     <= res_tag_next;
      res_timeout_reg <= res_timeout_next;
    end
  end

  assign alu_A       = alu_a_reg;
  assign alu_B       = alu_b_reg;
  assign alu_op      = alu_op_reg;
  assign alu_mode_fp = alu_mode_reg;
  assign res_valid   = res_valid_reg;
  assign res_q       = res_q_reg;
  assign res_tag     = res_tag_reg;
  assign res_timeout = res_timeout_reg;
  assign busy        = (state_reg != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_strokie_alu_issue.sv
// Directed plus randomized bench for strokie_alu_issue with a combinational
// ALU model whose ready can be delayed or suppressed.
module tb_strokie_alu_issue;
  import strokie_pkg::*;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid, req_ready;
  logic [31:0]      req_a, req_b;
  logic [1:0]       req_op;
  logic             req_mode_fp;
  logic [TAG_W-1:0] req_tag;
  logic [31:0]      alu_A, alu_B, alu_Q;
  logic [1:0]       alu_op;
  logic             alu_mode_fp, alu_ready;
  logic             res_valid, res_ready, res_timeout, busy;
  logic [31:0]      res_q;
  logic [TAG_W-1:0] res_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  strokie_alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_mode_fp(req_mode_fp), .req_tag(req_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op), .alu_mode_fp(alu_mode_fp),
    .alu_Q(alu_Q), .alu_ready(alu_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_tag(res_tag),
    .res_timeout(res_timeout), .busy(busy)
  );

  // ALU model: known FP sums by table, otherwise an operand-sensitive hash.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op, input logic mode);
    if (op == OP_ADD && mode && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (op == OP_ADD && !mode && a == 32'h3C000000 && b == 32'h3C000000) return 32'h40000000;
    if (op == OP_ADD && mode && a == 32'h40490FD8 && b == 32'h402DF854) return 32'h40BB8416;
    if (op == OP_ADD && mode && a == 32'h3DCCCCCD && b == 32'h3E4CCCCD) return 32'h3E99999A;
    return ((a * 32'd3) + {b[15:0], b[31:16]}) ^ (mode ? 32'h12345678 : 32'h87654321) ^ {30'd0, op};
  endfunction

  assign alu_Q = alu_fn(alu_A, alu_B, alu_op, alu_mode_fp);

  // ALU ready model: asserted once the ALU inputs have been steady for ready_delay cycles.
  int          ready_delay = 0;
  bit          ready_never = 1'b0;
  logic [66:0] prev_ops = '0;
  int          ops_age = 0;
  always @(posedge clk) begin
    if ({alu_A, alu_B, alu_op, alu_mode_fp} != prev_ops) ops_age <= 0;
    else if (ops_age < 1000) ops_age <= ops_age + 1;
    prev_ops <= {alu_A, alu_B, alu_op, alu_mode_fp};
  end
  assign alu_ready = !ready_never && (ops_age >= ready_delay);

  typedef struct {
    logic [31:0]      q;
    logic [TAG_W-1:0] tag;
    logic             to;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] exp_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [1:0] op, input logic mode);
    logic [31:0] pa, pb, q;
    pa = mode ? a : {a[15:0], 16'h0};
    pb = mode ? b : {b[15:0], 16'h0};
    q  = alu_fn(pa, pb, op, mode);
    return mode ? q : {16'h0, q[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic mode, input logic [TAG_W-1:0] tag);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op; req_mode_fp = mode; req_tag = tag;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    chk("send_accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    e.tag = tag;
    if (ready_never) begin
      e.q = mode ? 32'h7FC00000 : 32'h00007E00; e.to = 1'b1;
    end else begin
      e.q = exp_result(a, b, op, mode); e.to = 1'b0;
    end
    exp_q.push_back(e);
    $display("push tag=%0d mode=%0d a=%h b=%h exp_q=%h", tag, mode, a, b, e.q);
    #1 req_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd);
    int   got = 0;
    exp_t e;
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      @(negedge clk);
      res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("result tag=%0d q=%h to=%0d", res_tag, res_q, res_timeout);
          chk("res_q", res_q, e.q);
          chk("res_tag", 32'(res_tag), 32'(e.tag));
          chk("res_timeout", 32'(res_timeout), 32'(e.to));
        end
        got++;
      end
    end
    chk("collect_count", 32'(got), 32'(n));
    @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_alu_A"}, alu_A, 32'h0);
    chk({name, "_alu_B"}, alu_B, 32'h0);
    chk({name, "_alu_op_mode"}, {29'd0, alu_op, alu_mode_fp}, 32'h0);
    chk({name, "_res_flags"}, {29'd0, res_valid, res_timeout, busy}, 32'h0);
    chk({name, "_res_q"}, res_q, 32'h0);
    chk({name, "_res_tag"}, 32'(res_tag), 32'h0);
    chk({name, "_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    int n;
    req_valid = 0; req_a = 0; req_b = 0; req_op = 0; req_mode_fp = 0; req_tag = 0;
    res_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;

    // 1: FP32 1+1 and latency
    send(32'h3F800000, 32'h3F800000, OP_ADD, MODE_FP32, 4'd3);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1_alu_A", alu_A, 32'h3F800000);
    chk("t1_alu_mode", 32'(alu_mode_fp), 32'd1);
    @(negedge clk);
    chk("t1_valid_e2", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("t1_valid_e3", 32'(res_valid), 32'd1);
    chk("t1_res_q", res_q, 32'h40000000);
    chk("t1_res_tag", 32'(res_tag), 32'd3);
    collect(1, 1'b0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // 2: FP16 packing/unpacking
    send(32'h00003C00, 32'h00003C00, OP_ADD, MODE_FP16, 4'd5);
    repeat (2) @(negedge clk);
    chk("t2_alu_A", alu_A, 32'h3C000000);
    chk("t2_alu_B", alu_B, 32'h3C000000);
    repeat (2) @(negedge clk);
    chk("t2_res_q", res_q, 32'h00004000);
    collect(1, 1'b0);

    // 3: backpressure, 5 accepted out of 6
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send($urandom, $urandom, OP_ADD, MODE_FP32, 4'(8 + i));
    @(negedge clk);
    chk("t3_full", 32'(req_ready), 32'd0);
    chk("t3_valid", 32'(res_valid), 32'd1);
    req_valid = 1'b1; req_tag = 4'd13; req_a = $urandom; req_b = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_still_full", 32'(req_ready), 32'd0);
      chk("t3_hold_q", res_q, exp_q[0].q);
      chk("t3_hold_tag", 32'(res_tag), 32'(exp_q[0].tag));
    end
    req_valid = 1'b0;
    collect(5, 1'b0);
    @(negedge clk);
    chk("t3_drained", 32'(busy), 32'd0);

    // 4: timeout, FP32 then FP16
    ready_never = 1'b1;
    for (int m = 1; m >= 0; m--) begin
      send($urandom, $urandom, OP_ADD, 1'(m), 4'(6 + m));
      repeat (18) @(negedge clk);
      chk("t4_not_yet", 32'(res_valid), 32'd0);
      @(negedge clk);
      chk("t4_valid", 32'(res_valid), 32'd1);
      chk("t4_qnan", res_q, m ? 32'h7FC00000 : 32'h00007E00);
      chk("t4_timeout", 32'(res_timeout), 32'd1);
      collect(1, 1'b0);
    end
    ready_never = 1'b0;

    // 5: alu_ready stuck high
    ready_delay = 0;
    send(32'h40490FD8, 32'h402DF854, OP_ADD, MODE_FP32, 4'd1);
    send(32'h3DCCCCCD, 32'h3E4CCCCD, OP_ADD, MODE_FP32, 4'd2);
    chk("t5_model_pi_e", exp_q[0].q, 32'h40BB8416);
    collect(2, 1'b0);

    // Randomized batches
    for (int bt = 0; bt < 6; bt++) begin
      ready_delay = $urandom_range(0, 3);
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++)
        send($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)));
      collect(n, 1'b1);
    end

    // 6: async reset while in WAIT with two queued
    ready_never = 1'b1;
    send(32'h11111111, 32'h22222222, OP_ADD, MODE_FP32, 4'd9);
    send(32'h33333333, 32'h44444444, OP_ADD, MODE_FP32, 4'd10);
    send(32'h55555555, 32'h66666666, OP_ADD, MODE_FP32, 4'd11);
    repeat (3) @(negedge clk);
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1 chk_idle_outputs("t6_reset");
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ready_never = 1'b0;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    chk("t6_no_result", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

endmodule
